// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data width, output FIFO geometry
// and the layout of the packet header byte.
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam int PKT_CNT_W = 7;

endpackage

// File: rtl/router_fifo.sv
// Per-destination output buffer: stores bytes tagged with a header marker and
// tracks remaining packet length on the read side to clear the output bus.
module router_fifo #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = router_pkg::FIFO_DEPTH,
  parameter int ADDR_W = router_pkg::FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);
  import router_pkg::HDR_LEN_MSB;
  import router_pkg::HDR_LEN_LSB;
  import router_pkg::PKT_CNT_W;

  logic [DATA_W:0]    mem [DEPTH];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [DATA_W:0]    rd_word;
  logic               do_wr;
  logic               do_rd;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
              (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    do_wr   = write_enb && !full;
    do_rd   = read_enb && !empty;
    rd_word = mem[rd_ptr[ADDR_W-1:0]];
  end

  // Storage is not reset; the flush and reset gating only protect the write.
  always_ff @(posedge clk) begin
    if (resetn && !soft_reset && do_wr)
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        data_out <= rd_word[DATA_W-1:0];
        rd_ptr   <= rd_ptr + 1'b1;
        if (rd_word[DATA_W])
          pkt_cnt <= PKT_CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - 1'b1;
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router. Three instances sit directly downstream of the synchronizer.
- Each instance consumes its `write_enb[i]` and `soft_reset_i`, and returns `full_i` / `empty_i` to the synchronizer.
- Stores header, payload and parity bytes with a header-marker bit.
- Tracks the remaining packet length on the read side so the output bus is cleared at packet end.

Parameters:
- DATA_W, 8, byte width of stored data.
- DEPTH, 16, number of entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits wide.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- soft_reset  in  1  synchronous flush from synchronizer time-out, active-high
- write_enb  in  1  write request (one bit of the synchronizer's `write_enb` bus)
- read_enb  in  1  read request from downstream client
- lfd_state  in  1  high when the byte on data_in is a packet header
- data_in  in  DATA_W  byte to store
- data_out  out  DATA_W  registered read data
- full  out  1  high when DEPTH entries are occupied
- empty  out  1  high when 0 entries are occupied

Behaviour:
- Storage: DEPTH x (DATA_W+1). Bit DATA_W holds lfd_state captured with the byte.
- Pointers: wr_ptr and rd_ptr, each ADDR_W+1 bits. Low ADDR_W bits address storage; the MSB is the wrap bit.
- Flags, combinational from registered pointers:
  - empty = (wr_ptr == rd_ptr)
  - full = (low bits equal) and (MSBs differ)
- Write: when write_enb && !full, mem[wr_ptr] <= {lfd_state, data_in} and wr_ptr++. Write while full is dropped; no state change.
- Read: when read_enb && !empty, data_out <= mem[rd_ptr][DATA_W-1:0] and rd_ptr++. Latency is 1 cycle from read_enb to data_out. Read while empty is ignored.
- Simultaneous read and write:
  - Each is qualified against flags from the current cycle.
  - At full: read occurs, write is dropped.
  - At empty: write occurs, read is ignored.
  - Otherwise both occur and occupancy is unchanged.
- Packet counter pkt_cnt, 7 bits, updated only on a successful read:
  - Entry read has header bit set: pkt_cnt <= entry[7:2] + 1 (payload length + parity).
  - Otherwise, if pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
  - Header length field 0 loads pkt_cnt = 1 (parity only).
- data_out when no successful read this cycle:
  - pkt_cnt == 0: data_out <= 0.
  - Otherwise: hold the previous value.
- Reset (resetn low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, pkt_cnt = 0, data_out = 0.
  - Hence empty = 1, full = 0.
  - Memory contents are don't-care.
- soft_reset (synchronous, highest priority over read/write in that cycle):
  - Same register values as reset.
  - Any write or read in the same cycle is discarded.
  - Mid-packet flush: the remainder of the packet is lost. The next header written starts fresh.
- Wrap: pointers roll from 2*DEPTH-1 to 0 naturally; no special-casing.
- No X on outputs after reset; all outputs are registered or derived from registers.

Decomposition:
- Package `router_pkg`:
  - DATA_W, FIFO_DEPTH, FIFO_ADDR_W
  - header field constants: HDR_LEN_MSB = 7, HDR_LEN_LSB = 2, HDR_ADDR_MSB = 1, HDR_ADDR_LSB = 0
  - PKT_CNT_W = 7
- No sub-module. Storage, pointer and counter logic stay in one module; the block is small enough.

Test Plan:
- Normal packet:
  - Stimulus: write header 0x0D with lfd_state=1 (len 3, addr 01), then 0xA1, 0xA2, 0xA3, parity 0x5C; then read_enb held 5 cycles.
  - Response: data_out = 0x0D, A1, A2, A3, 5C on successive cycles, each 1 cycle after read_enb.
  - pkt_cnt = 4, 3, 2, 1, 0; the next idle cycle gives data_out = 0x00 and empty = 1.
- Fill and overflow:
  - Stimulus: 17 consecutive writes of 0x00..0x10, no reads.
  - Response: full = 1 after the 16th write; 0x10 is dropped; 16 reads return 0x00..0x0F, then empty = 1.
- Simultaneous access:
  - At full with read_enb = write_enb = 1: occupancy drops to 15 and full = 0.
  - At empty with both asserted: occupancy becomes 1 and data_out is unchanged.
- Soft reset mid-packet:
  - Stimulus: after reading header and 1 payload byte of a len-3 packet, pulse soft_reset for 1 cycle.
  - Response: next cycle empty = 1, data_out = 0, pkt_cnt = 0.
  - A new header 0x05 then reads back correctly.
- Async reset mid-operation:
  - Stimulus: drop resetn between clock edges while 8 entries are held.
  - Response: immediately empty = 1, full = 0, data_out = 0; writes are ignored until resetn rises.
- Wrap-around:
  - Stimulus: 40 writes interleaved with reads at occupancy ≤ 5.
  - Response: data_out sequence is identical to the input order; full is never asserted.
